// File: rtl/mem_bus_pkg.sv
// Shared definitions for the 16-bit static RAM bus master: FSM encodings,
// bus error cause codes and the default top of populated memory.
package mem_bus_pkg;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StSetup  = 3'd1,
        StAccess = 3'd2,
        StDone   = 3'd3,
        StFault  = 3'd4
    } bus_state_e;

    localparam logic ERR_NXM = 1'b0;
    localparam logic ERR_ODD = 1'b1;

    localparam logic [15:0] MEM_TOP_DEFAULT = 16'o040000;

endpackage

// File: rtl/mem_byte_lane.sv
// Byte-lane steering for the RAM bus: replicates the write byte onto both lanes
// and zero-extends byte reads taken from the low lane.
module mem_byte_lane (
    input  logic        byte_op,
    input  logic [15:0] wdata,
    input  logic [15:0] rd_raw,
    output logic [15:0] di,
    output logic [15:0] rdata
);

    always_comb begin
        di    = byte_op ? {wdata[7:0], wdata[7:0]} : wdata;
        rdata = byte_op ? {8'h00, rd_raw[7:0]} : rd_raw;
    end

endmodule

// File: rtl/mem_bus_master.sv
// Initiator for the 16-bit static RAM: sequences strobes, steers byte lanes and
// reports odd-address / nonexistent-memory faults. BUS_NXM_EN enables the MEM_TOP check.
module mem_bus_master
    import mem_bus_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = 1,
    parameter logic [15:0] MEM_TOP     = MEM_TOP_DEFAULT
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        req,
    input  logic        we,
    input  logic        byte_op,
    input  logic [15:0] addr,
    input  logic [15:0] wdata,
    output logic        ack,
    output logic [15:0] rdata,
    output logic        err,
    output logic        err_odd,
    output logic        busy,
    output logic [15:0] A,
    output logic [15:0] DI,
    input  logic [15:0] DO,
    output logic        CE_N,
    output logic        WE_N,
    output logic        BYTE_OP
);

    localparam logic [3:0] WaitLoad = 4'(WAIT_CYCLES - 1);

    bus_state_e  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic        nxm;
    logic        fault_odd;
    logic        lane_sel;
    logic [15:0] lane_di, lane_rdata;
    logic [15:0] a_d, di_d, rdata_d;
    logic        byte_op_d, ack_d, err_d, err_odd_d, busy_d, ce_n_d, we_n_d;

`ifdef BUS_NXM_EN
    assign nxm = (addr >= MEM_TOP);
`else
    // Range check compiled out: every address aliases into the RAM via A[13:1].
    assign nxm = 1'b0 && (addr >= MEM_TOP);
`endif

    // In IDLE the lane steers the incoming request; afterwards the latched byte mode.
    assign lane_sel = (state_q == StIdle) ? byte_op : BYTE_OP;

    mem_byte_lane u_lane (
        .byte_op (lane_sel),
        .wdata   (wdata),
        .rd_raw  (DO),
        .di      (lane_di),
        .rdata   (lane_rdata)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        we_d      = we_q;
        fault_odd = ERR_NXM;
        a_d       = A;
        di_d      = DI;
        byte_op_d = BYTE_OP;
        rdata_d   = rdata;

        unique case (state_q)
            StIdle: begin
                if (req) begin
                    we_d = we;
                    if (!byte_op && addr[0]) begin
                        state_d   = StFault;
                        fault_odd = ERR_ODD;
                    end else if (nxm) begin
                        state_d   = StFault;
                        fault_odd = ERR_NXM;
                    end else begin
                        state_d   = StSetup;
                        a_d       = addr;
                        di_d      = lane_di;
                        byte_op_d = byte_op;
                    end
                end
            end
            StSetup: begin
                state_d = StAccess;
                cnt_d   = WaitLoad;
            end
            StAccess: begin
                if (cnt_q == 4'd0) begin
                    state_d = StDone;
                    if (!we_q) rdata_d = lane_rdata;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StDone:  state_d = StIdle;
            StFault: state_d = StIdle;
            default: state_d = StIdle;
        endcase

        // Outputs are registered, so they are derived from the state being entered.
        ack_d     = (state_d == StDone) || (state_d == StFault);
        err_d     = (state_d == StFault);
        err_odd_d = (state_d == StFault) ? fault_odd : 1'b0;
        busy_d    = (state_d != StIdle);
        ce_n_d    = !((state_d == StSetup) || (state_d == StAccess));
        we_n_d    = !((state_d == StAccess) && we_d && (cnt_d == 4'd0));
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            A       <= 16'd0;
            DI      <= 16'd0;
            BYTE_OP <= 1'b0;
            CE_N    <= 1'b1;
            WE_N    <= 1'b1;
            ack     <= 1'b0;
            rdata   <= 16'd0;
            err     <= 1'b0;
            err_odd <= 1'b0;
            busy    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            A       <= a_d;
            DI      <= di_d;
            BYTE_OP <= byte_op_d;
            CE_N    <= ce_n_d;
            WE_N    <= we_n_d;
            ack     <= ack_d;
            rdata   <= rdata_d;
            err     <= err_d;
            err_odd <= err_odd_d;
            busy    <= busy_d;
        end
    end

endmodule

// File: tb/tb_mem_bus_master.sv
// Directed bench for mem_bus_master (WAIT_CYCLES=3) against a behavioural 16-bit RAM.
module tb_mem_bus_master;

    localparam int unsigned WAIT = 3;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        req, we, byte_op;
    logic [15:0] addr, wdata;
    logic        ack, err, err_odd, busy;
    logic [15:0] rdata, A, DI, DO;
    logic        CE_N, WE_N, BYTE_OP;

    int n_checks = 0;
    int n_errors = 0;
    int we_low_cnt = 0;
    int ce_low_cnt = 0;
    int ack_cnt = 0;

    logic [15:0] mem [0:8191];
    logic [15:0] mem_word;

    always #5 CLK = ~CLK;

    mem_bus_master #(.WAIT_CYCLES(WAIT)) u_dut (
        .CLK     (CLK),
        .RESET   (RESET),
        .req     (req),
        .we      (we),
        .byte_op (byte_op),
        .addr    (addr),
        .wdata   (wdata),
        .ack     (ack),
        .rdata   (rdata),
        .err     (err),
        .err_odd (err_odd),
        .busy    (busy),
        .A       (A),
        .DI      (DI),
        .DO      (DO),
        .CE_N    (CE_N),
        .WE_N    (WE_N),
        .BYTE_OP (BYTE_OP)
    );

    // RAM: byte reads present the selected byte on the low lane.
    always_comb begin
        mem_word = mem[A[13:1]];
        DO = BYTE_OP ? {8'h00, (A[0] ? mem_word[15:8] : mem_word[7:0])} : mem_word;
    end

    always @(posedge CLK) begin
        if (!CE_N && !WE_N) begin
            if (!BYTE_OP)  mem[A[13:1]]       <= DI;
            else if (A[0]) mem[A[13:1]][15:8] <= DI[15:8];
            else           mem[A[13:1]][7:0]  <= DI[7:0];
        end
    end

    always @(negedge CLK) begin
        if (!WE_N) we_low_cnt++;
        if (!CE_N) ce_low_cnt++;
        if (ack)   ack_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Presents one request; lat counts cycles from the sampling edge to the ack cycle.
    task automatic bus_access(input logic w, input logic b, input logic [15:0] ad,
                              input logic [15:0] wd, input bit hold,
                              output logic [15:0] rd, output logic e, output logic eo,
                              output int lat);
        @(negedge CLK);
        req = 1'b1; we = w; byte_op = b; addr = ad; wdata = wd;
        lat = 0;
        do begin
            @(negedge CLK);
            lat++;
        end while (ack !== 1'b1 && lat < 64);
        rd = rdata; e = err; eo = err_odd;
        if (!hold) req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] rd;
        logic        e, eo;
        int          lat, w0, c0, a0;

        RESET = 1'b1; req = 1'b0; we = 1'b0; byte_op = 1'b0; addr = '0; wdata = '0;
        repeat (2) @(negedge CLK);
        check("rst_A", A, 16'd0);
        check("rst_DI", DI, 16'd0);
        check("rst_strobes", {CE_N, WE_N, BYTE_OP}, 3'b110);
        check("rst_flags", {ack, err, err_odd, busy}, 4'b0000);
        check("rst_rdata", rdata, 16'd0);
        RESET = 1'b0;

        w0 = we_low_cnt;
        bus_access(1'b1, 1'b0, 16'o000500, 16'o012706, 1'b0, rd, e, eo, lat);
        check("wwr_lat", lat, 32'd5);
        check("wwr_err", e, 1'b0);
        check("wwr_we_pulses", we_low_cnt - w0, 32'd1);

        bus_access(1'b0, 1'b0, 16'o000500, 16'o0, 1'b0, rd, e, eo, lat);
        check("wrd_lat", lat, 32'd5);
        check("wrd_err", e, 1'b0);
        check("wrd_data", rd, 16'o012706);

        w0 = we_low_cnt;
        bus_access(1'b1, 1'b1, 16'o000501, 16'o000377, 1'b0, rd, e, eo, lat);
        check("bwr_err", e, 1'b0);
        check("bwr_we_pulses", we_low_cnt - w0, 32'd1);

        bus_access(1'b0, 1'b0, 16'o000500, 16'o0, 1'b0, rd, e, eo, lat);
        check("wrd_after_bwr", rd, 16'o177706);
        bus_access(1'b0, 1'b1, 16'o000500, 16'o0, 1'b0, rd, e, eo, lat);
        check("brd_even", rd, 16'o000306);
        bus_access(1'b0, 1'b1, 16'o000501, 16'o0, 1'b0, rd, e, eo, lat);
        check("brd_odd", rd, 16'o000377);
        check("brd_odd_err", e, 1'b0);

        c0 = ce_low_cnt;
        bus_access(1'b0, 1'b0, 16'o000503, 16'o0, 1'b0, rd, e, eo, lat);
        check("odd_lat", lat, 32'd1);
        check("odd_err", {e, eo}, 2'b11);
        check("odd_no_ce", ce_low_cnt - c0, 32'd0);

        bus_access(1'b1, 1'b0, 16'o000000, 16'o123456, 1'b0, rd, e, eo, lat);
        c0 = ce_low_cnt;
        bus_access(1'b0, 1'b0, 16'o040000, 16'o0, 1'b0, rd, e, eo, lat);
`ifdef BUS_NXM_EN
        check("nxm_lat", lat, 32'd1);
        check("nxm_err", {e, eo}, 2'b10);
        check("nxm_no_ce", ce_low_cnt - c0, 32'd0);
`else
        check("alias_lat", lat, 32'd5);
        check("alias_err", e, 1'b0);
        check("alias_data", rd, 16'o123456);
`endif

        // req held high through ack starts a second access right after DONE.
        bus_access(1'b0, 1'b0, 16'o000500, 16'o0, 1'b1, rd, e, eo, lat);
        check("b2b_first", rd, 16'o177706);
        lat = 0;
        do begin
            @(negedge CLK);
            lat++;
        end while (ack !== 1'b1 && lat < 64);
        req = 1'b0;
        check("b2b_period", lat, 32'd6);
        check("b2b_second", rdata, 16'o177706);

        // Reset in the first of three ACCESS cycles of a write.
        w0 = we_low_cnt;
        @(negedge CLK);
        req = 1'b1; we = 1'b1; byte_op = 1'b0; addr = 16'o000500; wdata = 16'o055555;
        repeat (2) @(negedge CLK);
        check("rst_mid_ce_active", CE_N, 1'b0);
        a0 = ack_cnt;
        RESET = 1'b1;
        #1;
        check("rst_mid_strobes", {CE_N, WE_N}, 2'b11);
        check("rst_mid_ack", {ack, busy}, 2'b00);
        req = 1'b0;
        @(negedge CLK);
        RESET = 1'b0;
        repeat (6) @(negedge CLK);
        check("rst_mid_no_ack", ack_cnt - a0, 32'd0);
        check("rst_mid_no_write", we_low_cnt - w0, 32'd0);
        bus_access(1'b0, 1'b0, 16'o000500, 16'o0, 1'b0, rd, e, eo, lat);
        check("rst_mid_old_data", rd, 16'o177706);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
